// File: rtl/history_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module   : history_buffer_if
//  Purpose  : Bundles the player-facing controls and the history display
//             outputs of history_buffer into one interface.
//  Signals  : mode          - 0 = guess mode, 1 = history (browse) mode
//             btn_up        - level input, browse forward
//             btn_down      - level input, browse backward
//             btn_select    - level input, commit current guess
//             guess         - current guess, peg i at [i*COLOR_W +: COLOR_W]
//             selection     - displayed history entry, same packing
//             selected_turn - index of the displayed entry
//             turn_count    - number of committed turns
//             last_turn     - buffer full
//             commit_ack    - one-cycle pulse per accepted commit
//             commit_rej    - one-cycle pulse per refused commit
//  Modports : master (player / bench side), slave (history_buffer side)
//  Revision : 1.0 - initial release
// ============================================================================
interface history_buffer_if #(
  parameter int PEGS    = 4,
  parameter int COLOR_W = 3,
  parameter int DEPTH   = 8
);
  localparam int TW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic                    mode;
  logic                    btn_up;
  logic                    btn_down;
  logic                    btn_select;
  logic [PEGS*COLOR_W-1:0] guess;
  logic [PEGS*COLOR_W-1:0] selection;
  logic [TW-1:0]           selected_turn;
  logic [CW-1:0]           turn_count;
  logic                    last_turn;
  logic                    commit_ack;
  logic                    commit_rej;

  modport master (
    output mode, btn_up, btn_down, btn_select, guess,
    input  selection, selected_turn, turn_count, last_turn, commit_ack, commit_rej
  );

  modport slave (
    input  mode, btn_up, btn_down, btn_select, guess,
    output selection, selected_turn, turn_count, last_turn, commit_ack, commit_rej
  );
endinterface
`default_nettype wire

// File: rtl/history_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : history_buffer
//  Purpose  : Stores up to DEPTH committed guesses of a code-breaking game
//             and lets the player browse them with up/down buttons.
//  Ports    : clk   - single clock, rising edge
//             reset - asynchronous, active-low
//             bus   - history_buffer_if.slave (controls in, display out)
//  Revision : 1.0 - initial release
// ============================================================================
module history_buffer #(
  parameter int PEGS    = 4,
  parameter int COLOR_W = 3,
  parameter int DEPTH   = 8
) (
  input  logic             clk,
  input  logic             reset,
  history_buffer_if.slave  bus
);
  localparam int TW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int DW = PEGS * COLOR_W;
  localparam logic [CW-1:0] c_DEPTH = CW'(DEPTH);

  typedef enum logic [1:0] {
    GUESS  = 2'd0,
    BROWSE = 2'd1,
    FULL   = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;

  logic            r_up_q;
  logic            r_down_q;
  logic            r_sel_q;
  logic [DW-1:0]   r_entries [DEPTH];
  logic [CW-1:0]   r_turn_count;
  logic [TW-1:0]   r_selected_turn;
  logic [DW-1:0]   r_selection;
  logic            r_last_turn;
  logic            r_commit_ack;
  logic            r_commit_rej;

  logic            w_up_edge;
  logic            w_down_edge;
  logic            w_sel_edge;
  logic            w_commit;
  logic            w_reject;
  logic [TW-1:0]   w_latest;
  logic [TW-1:0]   w_sel_turn_next;
  logic [CW-1:0]   w_turn_next;

  // A held button yields one edge: only the first cycle sees a 0 copy.
  assign w_up_edge   = bus.btn_up     & ~r_up_q;
  assign w_down_edge = bus.btn_down   & ~r_down_q;
  assign w_sel_edge  = bus.btn_select & ~r_sel_q;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= GUESS;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Commits and rejects are only evaluated while mode is 0, so a select
  // edge coinciding with mode rising is dropped.
  always_comb begin
    w_state_next = r_state;
    w_commit     = 1'b0;
    w_reject     = 1'b0;
    case (r_state)
      GUESS: begin
        if (bus.mode) begin
          w_state_next = BROWSE;
        end else if (w_sel_edge && (r_turn_count != c_DEPTH)) begin
          w_commit = 1'b1;
          if (r_turn_count == c_DEPTH - CW'(1)) begin
            w_state_next = FULL;
          end
        end
      end
      BROWSE: begin
        if (!bus.mode) begin
          w_state_next = (r_turn_count == c_DEPTH) ? FULL : GUESS;
        end
      end
      FULL: begin
        if (bus.mode) begin
          w_state_next = BROWSE;
        end else if (w_sel_edge) begin
          w_reject = 1'b1;
        end
      end
      default: begin
        w_state_next = GUESS;
      end
    endcase
  end

  // ------------------------------------------------- turn / cursor logic
  always_comb begin
    w_latest        = (r_turn_count == '0) ? '0 : TW'(r_turn_count - CW'(1));
    w_turn_next     = w_commit ? (r_turn_count + CW'(1)) : r_turn_count;
    w_sel_turn_next = r_selected_turn;
    if (r_state == BROWSE) begin
      // Opposing edges in the same cycle cancel out.
      if (w_up_edge && !w_down_edge &&
          ((CW'(r_selected_turn) + CW'(1)) < r_turn_count)) begin
        w_sel_turn_next = r_selected_turn + TW'(1);
      end else if (w_down_edge && !w_up_edge && (r_selected_turn != '0)) begin
        w_sel_turn_next = r_selected_turn - TW'(1);
      end
    end else if (w_commit) begin
      // Newly written entry becomes the latest one.
      w_sel_turn_next = TW'(r_turn_count);
    end else begin
      // Outside browsing the cursor follows the latest entry, which also
      // makes it correct on entry into BROWSE.
      w_sel_turn_next = w_latest;
    end
  end

  // ------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_up_q          <= 1'b0;
      r_down_q        <= 1'b0;
      r_sel_q         <= 1'b0;
      r_turn_count    <= '0;
      r_selected_turn <= '0;
      r_selection     <= '0;
      r_last_turn     <= 1'b0;
      r_commit_ack    <= 1'b0;
      r_commit_rej    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_entries[i] <= '0;
      end
    end else begin
      r_up_q          <= bus.btn_up;
      r_down_q        <= bus.btn_down;
      r_sel_q         <= bus.btn_select;
      if (w_commit) begin
        r_entries[TW'(r_turn_count)] <= bus.guess;
      end
      r_turn_count    <= w_turn_next;
      r_selected_turn <= w_sel_turn_next;
      // Entries are cleared on reset, so an empty buffer displays zeros.
      r_selection     <= r_entries[r_selected_turn];
      r_last_turn     <= (w_turn_next == c_DEPTH);
      r_commit_ack    <= w_commit;
      r_commit_rej    <= w_reject;
    end
  end

  assign bus.selection     = r_selection;
  assign bus.selected_turn = r_selected_turn;
  assign bus.turn_count    = r_turn_count;
  assign bus.last_turn     = r_last_turn;
  assign bus.commit_ack    = r_commit_ack;
  assign bus.commit_rej    = r_commit_rej;
endmodule
`default_nettype wire

// File: tb/tb_history_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_history_buffer
//  Purpose  : Self-checking bench for history_buffer. Two instances:
//             A (PEGS=4, COLOR_W=3, DEPTH=8) and B (PEGS=5, COLOR_W=4,
//             DEPTH=4). Stimulus queues expected commit responses and state
//             probes; a monitor compares them against the DUT outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_history_buffer;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  history_buffer_if #(.PEGS(4), .COLOR_W(3), .DEPTH(8)) bus_a ();
  history_buffer_if #(.PEGS(5), .COLOR_W(4), .DEPTH(4)) bus_b ();

  history_buffer #(.PEGS(4), .COLOR_W(3), .DEPTH(8)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  history_buffer #(.PEGS(5), .COLOR_W(4), .DEPTH(4)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  // kind: 0 = state probe, 1 = ack expected, 2 = rej expected, 3 = drain
  typedef struct packed {
    int d;
    int kind;
    int tc;
    int st;
    int sel;
    int last;
  } exp_t;

  exp_t  ackq0 [$];
  exp_t  ackq1 [$];
  exp_t  pq    [$];
  string pn    [$];

  int checks   = 0;
  int failures = 0;
  int tc_m [2] = '{0, 0};
  int dep  [2] = '{8, 4};

  // ------------------------------------------------------------ accessors
  function automatic int get_tc(input int d);
    if (d == 0) return int'(bus_a.turn_count);
    return int'(bus_b.turn_count);
  endfunction
  function automatic int get_st(input int d);
    if (d == 0) return int'(bus_a.selected_turn);
    return int'(bus_b.selected_turn);
  endfunction
  function automatic int get_sel(input int d);
    if (d == 0) return int'(bus_a.selection);
    return int'(bus_b.selection);
  endfunction
  function automatic int get_last(input int d);
    if (d == 0) return int'(bus_a.last_turn);
    return int'(bus_b.last_turn);
  endfunction
  function automatic logic get_ack(input int d);
    if (d == 0) return bus_a.commit_ack;
    return bus_b.commit_ack;
  endfunction
  function automatic logic get_rej(input int d);
    if (d == 0) return bus_a.commit_rej;
    return bus_b.commit_rej;
  endfunction

  // ------------------------------------------------------------ checking
  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  task automatic check_pulses(input int d);
    logic a;
    logic r;
    exp_t e;
    int   qsz;
    a   = get_ack(d);
    r   = get_rej(d);
    qsz = (d == 0) ? ackq0.size() : ackq1.size();
    if (a || r) begin
      if (a && r) begin
        chk($sformatf("dut%0d_ack_and_rej", d), 1, 0);
      end else if (qsz == 0) begin
        chk($sformatf("dut%0d_unexpected_pulse", d), a ? 1 : 2, 0);
      end else begin
        if (d == 0) e = ackq0.pop_front();
        else        e = ackq1.pop_front();
        chk($sformatf("dut%0d_pulse_kind", d), a ? 1 : 2, e.kind);
        chk($sformatf("dut%0d_pulse_turn_count", d), get_tc(d), e.tc);
        chk($sformatf("dut%0d_pulse_selected_turn", d), get_st(d), e.st);
        chk($sformatf("dut%0d_pulse_last_turn", d), get_last(d), e.last);
      end
    end
  endtask

  task automatic run_probe(input exp_t e, input string nm);
    if (e.kind == 3) begin
      chk({nm, "_missing_pulses"}, (e.d == 0) ? ackq0.size() : ackq1.size(), 0);
    end else begin
      chk({nm, "_turn_count"},    get_tc(e.d),   e.tc);
      chk({nm, "_selected_turn"}, get_st(e.d),   e.st);
      chk({nm, "_selection"},     get_sel(e.d),  e.sel);
      chk({nm, "_last_turn"},     get_last(e.d), e.last);
    end
  endtask

  always @(negedge clk) begin
    check_pulses(0);
    check_pulses(1);
    while (pq.size() > 0) begin
      run_probe(pq.pop_front(), pn.pop_front());
    end
  end

  // ------------------------------------------------------------ stimulus
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input int d, input logic m, input logic u,
                       input logic dn, input logic s);
    if (d == 0) begin
      bus_a.mode = m; bus_a.btn_up = u; bus_a.btn_down = dn; bus_a.btn_select = s;
    end else begin
      bus_b.mode = m; bus_b.btn_up = u; bus_b.btn_down = dn; bus_b.btn_select = s;
    end
  endtask

  task automatic press(input int d, input logic m, input logic u,
                       input logic dn, input logic s, input int hold);
    drive(d, m, u, dn, s);
    tick(hold);
    drive(d, m, 1'b0, 1'b0, 1'b0);
    tick(2);
  endtask

  task automatic probe(input string nm, input int d, input int tc,
                       input int st, input int sel, input int last);
    exp_t e;
    e.d = d; e.kind = 0; e.tc = tc; e.st = st; e.sel = sel; e.last = last;
    pq.push_back(e);
    pn.push_back(nm);
  endtask

  task automatic drain(input string nm, input int d);
    exp_t e;
    e.d = d; e.kind = 3; e.tc = 0; e.st = 0; e.sel = 0; e.last = 0;
    pq.push_back(e);
    pn.push_back(nm);
  endtask

  // Expected response of one select edge in guess mode.
  task automatic push_commit(input int d);
    exp_t e;
    e.d = d; e.sel = 0;
    if (tc_m[d] < dep[d]) begin
      tc_m[d]++;
      e.kind = 1;
    end else begin
      e.kind = 2;
    end
    e.tc   = tc_m[d];
    e.st   = tc_m[d] - 1;
    e.last = (tc_m[d] == dep[d]) ? 1 : 0;
    if (d == 0) ackq0.push_back(e);
    else        ackq1.push_back(e);
  endtask

  task automatic commit(input int d, input int g, input int hold);
    if (d == 0) bus_a.guess = 12'(g);
    else        bus_b.guess = 20'(g);
    push_commit(d);
    press(d, 1'b0, 1'b0, 1'b0, 1'b1, hold);
  endtask

  task automatic assert_reset();
    reset = 1'b0;
    tc_m[0] = 0;
    tc_m[1] = 0;
    probe("rst_a", 0, 0, 0, 0, 0);
    probe("rst_b", 1, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus_a.guess = '0;
    bus_b.guess = '0;
    drive(0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0, 1'b0, 1'b0);
    assert_reset();
    tick(2);
    reset = 1'b1;
    tick(1);

    // ---------------- instance B: 5 pegs x 4 bits, depth 4
    commit(1, 'h00001, 1);
    probe("b_c1", 1, 1, 0, 'h00001, 0);
    commit(1, 'h00020, 1);
    commit(1, 'h00300, 1);
    commit(1, 'h54000, 1);
    probe("b_full", 1, 4, 3, 'h54000, 1);
    commit(1, 'hFFFFF, 1);                          // refused
    probe("b_rej", 1, 4, 3, 'h54000, 1);
    drive(1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(2);
    press(1, 1'b1, 1'b1, 1'b0, 1'b0, 1);            // up saturates at 3
    probe("b_up_sat", 1, 4, 3, 'h54000, 1);
    press(1, 1'b1, 1'b0, 1'b1, 1'b0, 1);
    probe("b_down1", 1, 4, 2, 'h00300, 1);
    press(1, 1'b1, 1'b0, 1'b1, 1'b0, 1);
    press(1, 1'b1, 1'b0, 1'b1, 1'b0, 1);
    press(1, 1'b1, 1'b0, 1'b1, 1'b0, 1);            // down saturates at 0
    probe("b_down_sat", 1, 4, 0, 'h00001, 1);
    drive(1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(3);

    // ---------------- instance A: commit with held select
    commit(0, 'h001, 3);
    probe("a_commit1", 0, 1, 0, 'h001, 0);
    commit(0, 'h008, 1);
    probe("a_commit2", 0, 2, 1, 'h008, 0);
    drive(0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(2);
    probe("a_browse_enter", 0, 2, 1, 'h008, 0);
    press(0, 1'b1, 1'b0, 1'b1, 1'b0, 4);            // held down: one step
    probe("a_down_held", 0, 2, 0, 'h001, 0);
    press(0, 1'b1, 1'b0, 1'b1, 1'b0, 1);
    probe("a_down_sat", 0, 2, 0, 'h001, 0);
    press(0, 1'b1, 1'b1, 1'b0, 1'b0, 1);
    press(0, 1'b1, 1'b1, 1'b0, 1'b0, 1);
    probe("a_up_sat", 0, 2, 1, 'h008, 0);
    press(0, 1'b1, 1'b1, 1'b1, 1'b0, 1);            // opposing edges cancel
    probe("a_up_down", 0, 2, 1, 'h008, 0);
    press(0, 1'b1, 1'b0, 1'b0, 1'b1, 1);            // select in browse ignored
    probe("a_sel_browse", 0, 2, 1, 'h008, 0);
    drive(0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(2);
    // select edge in the cycle mode rises: dropped
    drive(0, 1'b1, 1'b0, 1'b0, 1'b1);
    tick(1);
    drive(0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(3);
    probe("a_mode_race", 0, 2, 1, 'h008, 0);
    press(0, 1'b0, 1'b0, 1'b1, 1'b0, 1);            // down in guess ignored
    probe("a_down_guess", 0, 2, 1, 'h008, 0);

    // ---------------- instance A: fill to depth 8, then refuse
    for (int k = 2; k < 8; k++) begin
      commit(0, k * 37 + 5, 1);
    end
    probe("a_full", 0, 8, 7, 264, 1);
    commit(0, 'hFFF, 1);
    probe("a_full_rej", 0, 8, 7, 264, 1);
    drive(0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(2);
    press(0, 1'b1, 1'b0, 1'b1, 1'b0, 1);
    probe("a_full_browse", 0, 8, 6, 227, 1);
    drive(0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(4);
    probe("a_back_full", 0, 8, 7, 264, 1);
    commit(0, 'hABC, 1);                            // still refused

    // ---------------- reset mid-browse, select held through release
    assert_reset();
    tick(2);
    reset = 1'b1;
    tick(1);
    commit(0, 'h001, 1);
    commit(0, 'h012, 1);
    commit(0, 'h123, 1);
    drive(0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(2);
    press(0, 1'b1, 1'b0, 1'b1, 1'b0, 1);
    probe("a_pre_reset", 0, 3, 1, 'h012, 0);
    tick(1);
    assert_reset();
    drive(0, 1'b0, 1'b0, 1'b0, 1'b1);
    bus_a.guess = 12'h7A5;
    tick(2);
    push_commit(0);
    reset = 1'b1;
    tick(1);
    drive(0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(2);
    probe("a_post_reset", 0, 1, 0, 'h7A5, 0);

    drain("drain_a", 0);
    drain("drain_b", 1);
    tick(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/history_buffer.md
HISTORY_BUFFER -- requirements
Module: history_buffer

Interface
REQ-001 SHALL have parameter PEGS, default 4, pegs per guess.
REQ-002 SHALL have parameter COLOR_W, default 3, bits per peg.
REQ-003 SHALL have parameter DEPTH, default 8, maximum stored turns (DEPTH >= 2); TW = ceil(log2(DEPTH)), CW = ceil(log2(DEPTH+1)).
REQ-004 SHALL have ports:
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low; 0 forces reset immediately.
- mode  in  1  0 = guess mode, 1 = history (browse) mode.
- btn_up  in  1  level input, browse forward.
- btn_down  in  1  level input, browse backward.
- btn_select  in  1  level input, commit current guess.
- guess  in  PEGS*COLOR_W  current guess; peg i at bits [i*COLOR_W +: COLOR_W].
- selection  out  PEGS*COLOR_W  displayed history entry, same packing.
- selected_turn  out  TW  index of displayed entry.
- turn_count  out  CW  number of committed turns.
- last_turn  out  1  buffer full (turn_count == DEPTH).
- commit_ack  out  1  one-cycle pulse per accepted commit.
- commit_rej  out  1  one-cycle pulse per refused commit.

Function
REQ-005 SHALL register btn_up, btn_down and btn_select once each; an "edge" is a cycle where the input is 1 and its registered copy is 0; held buttons produce exactly one edge.
REQ-006 SHALL store entries in a DEPTH x (PEGS*COLOR_W) register array indexed 0..DEPTH-1.
REQ-007 FSM states: GUESS, BROWSE, FULL. GUESS->BROWSE when mode=1; BROWSE->GUESS when mode=0 and turn_count<DEPTH; BROWSE->FULL when mode=0 and turn_count==DEPTH; GUESS->FULL on the commit that makes turn_count==DEPTH; FULL->BROWSE when mode=1.
REQ-008 GUESS, select edge, mode=0, turn_count<DEPTH: SHALL write guess into entry[turn_count], increment turn_count, pulse commit_ack next cycle.
REQ-009 Select edge in FULL: SHALL leave array and turn_count unchanged and pulse commit_rej next cycle.
REQ-010 Select edge while mode=1 (either state): SHALL be ignored, no ack/rej.
REQ-011 In GUESS/FULL, selected_turn SHALL track the most recent entry (turn_count-1; 0 when turn_count=0), updated the cycle after a commit.
REQ-012 On entering BROWSE, selected_turn SHALL equal turn_count-1 (0 if empty).
REQ-013 In BROWSE, up edge SHALL increment selected_turn, saturating at turn_count-1; down edge SHALL decrement, saturating at 0.
REQ-014 Simultaneous up and down edges SHALL be ignored; up/down edges outside BROWSE SHALL be ignored.
REQ-015 selection SHALL be registered and equal entry[selected_turn] one cycle after selected_turn changes or that entry is written; all zeros while turn_count=0.
REQ-016 last_turn SHALL be a registered 1 exactly while turn_count==DEPTH.
REQ-017 turn_count SHALL never exceed DEPTH; no wrap-around, no overwrite of older entries.
REQ-018 commit_ack and commit_rej SHALL never both be 1 and are each high for exactly one cycle per event.

Reset
REQ-019 reset=0 SHALL asynchronously clear: all entries, turn_count, selected_turn, selection, last_turn, commit_ack, commit_rej, button registers; FSM to GUESS.
REQ-020 Reset mid-browse or mid-commit SHALL discard the pending operation; first edge evaluated after release uses cleared button registers (a button held through release counts as an edge).
REQ-021 All outputs SHALL be 0 during reset.

Verification
REQ-022 Commit: guess=peg0=1 others 0, select held 3 cycles -> one commit_ack, turn_count=1, selection=1-0-0-0, selected_turn=0.
REQ-023 Browse: commit 1-0-0-0 then 0-1-0-0, mode=1 -> selected_turn=1, selection=0-1-0-0; down held 4 cycles -> one step, selected_turn=0, selection=1-0-0-0; down again -> stays 0; up, up -> saturates at 1.
REQ-024 Full: DEPTH=8, 8 distinct commits -> last_turn=1 after 8th; 9th select -> commit_rej, turn_count=8, entry[7] unchanged.
REQ-025 Mode race: select edge in same cycle mode rises -> no commit, no ack/rej, turn_count unchanged.
REQ-026 Reset: after 3 commits in BROWSE at turn 1, reset=0 mid-cycle -> all outputs 0 immediately; after release, commit writes entry[0].
REQ-027 Parameters: PEGS=5, COLOR_W=4, DEPTH=4 -> packing and saturation correct, last_turn after 4 commits.
